sp_ram_ctl: RTL

Parametrised single-port synchronous RAM with request handshake, per-lane write enables, selectable write-response mode and a hardware clear sequencer. It is the next-generation replacement for the fixed 8-bit × 64-word single-port RAM. It sits between a bus master or datapath and on-chip storage. After reset, and on request, it autonomously fills every word with a constant before it accepts traffic.

---
 rtl/sp_ram_pkg.sv | 12 +
 rtl/sp_ram_array.sv | 41 ++++
 rtl/sp_ram_ctl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and mode constants for the sp_ram_ctl slice.
package sp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int WR_RESP_NONE       = 0;
  localparam int WR_RESP_READ_FIRST = 1;

endpackage

// File: rtl/sp_ram_array.sv
// Single-port storage with per-lane write enables and a registered, read-first read port.
module sp_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int LANE_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [DATA_W/LANE_W-1:0]   lane_en,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int NL = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage itself is never reset; only the clear sweep and writes define it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NL; i++) begin
        if (lane_en[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sp_ram_ctl.sv
// Single-port RAM controller: clear sweep FSM, request handshake, range check
// and optional output register around sp_ram_array.
module sp_ram_ctl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 64,
  parameter int                LANE_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                OUT_REG  = 0,
  parameter int                WR_RESP  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     we,
  input  logic [DATA_W/LANE_W-1:0] be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        data,
  output logic [DATA_W-1:0]        q,
  output logic                     rd_valid,
  output logic                     busy
);

  import sp_ram_pkg::*;

  localparam int                NL        = DATA_W / LANE_W;
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] ptr;

  logic              accept;
  logic              in_range;
  logic              resp;

  logic              arr_we;
  logic              arr_re;
  logic [NL-1:0]     arr_lanes;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              v1;
  logic              zero1;
  logic [DATA_W-1:0] q1;

  // Handshake: a request transfers on a cycle where req_valid && req_ready.
  // req_ready depends only on state and clr_req; the master must hold its
  // request (valid and payload) stable until it transfers.
  assign req_ready = (state == ST_IDLE) && !clr_req;
  assign busy      = (state == ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, addr} < DEPTH_EXT);
  assign resp      = accept && (!we || (WR_RESP != WR_RESP_NONE));

  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_lanes = '0;
    arr_addr  = addr;
    arr_wdata = data;
    if (state == ST_CLEAR) begin
      arr_we    = 1'b1;
      arr_lanes = '1;
      arr_addr  = ptr;
      arr_wdata = INIT_VAL;
    end else begin
      arr_we    = accept && we && in_range;
      arr_lanes = be;
      arr_re    = resp && in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_req) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            state <= ST_IDLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  sp_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LANE_W (LANE_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (arr_we),
    .lane_en (arr_lanes),
    .re      (arr_re),
    .addr    (arr_addr),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata)
  );

  // zero1 only moves with a returning response so q holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      zero1 <= 1'b0;
    end else begin
      v1 <= resp;
      if (resp) begin
        zero1 <= !in_range;
      end
    end
  end

  assign q1 = zero1 ? '0 : arr_rdata;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              v2;
      logic [DATA_W-1:0] q2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          q2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) begin
            q2 <= q1;
          end
        end
      end
      assign rd_valid = v2;
      assign q        = q2;
    end else begin : g_noreg
      assign rd_valid = v1;
      assign q        = q1;
    end
  endgenerate

endmodule
